// File: rtl/load_extend_controller.sv
// =============================================================================
//  Module   : load_extend_controller
//  Purpose  : Sequences one data-memory load: aligned read, lane select, extend.
//             Optional macro LOAD_TIMEOUT_EN bounds the wait for mem_ack.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module load_extend_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           se_input,
    output logic [2:0]            se_control,
    input  logic [31:0]           se_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        EXTEND = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        misaligned;
    logic        timeout_hit;
    logic [2:0]  control_next;
    logic [31:0] lane_data;

    assign req_ready  = (state == IDLE);
    assign misaligned = (req_size == 2'd3)
                      || ((req_size == 2'd1) && req_addr[0])
                      || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

`ifdef LOAD_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_count;

    // Idle clears the count, so it is always zero on entry to READ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_count <= '0;
        end else if (state == IDLE) begin
            wait_count <= '0;
        end else if ((state == READ) && !mem_ack) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    assign timeout_hit = (state == READ) && (wait_count == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        control_next = 3'd0;
        case (req_size)
            2'd0:    control_next = req_signed ? 3'd2 : 3'd4;
            2'd1:    control_next = req_signed ? 3'd1 : 3'd3;
            default: control_next = 3'd0;
        endcase
    end

    always_comb begin
        lane_data = mem_rdata;
        case (size_q)
            2'd0: begin
                case (lane_q)
                    2'd0:    lane_data = {24'd0, mem_rdata[7:0]};
                    2'd1:    lane_data = {24'd0, mem_rdata[15:8]};
                    2'd2:    lane_data = {24'd0, mem_rdata[23:16]};
                    default: lane_data = {24'd0, mem_rdata[31:24]};
                endcase
            end
            2'd1:    lane_data = lane_q[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
            default: lane_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (req_valid) state_next = misaligned ? RESP : READ;
            READ: begin
                // A same-cycle ack beats the timeout.
                if (mem_ack)          state_next = EXTEND;
                else if (timeout_hit) state_next = RESP;
            end
            EXTEND: state_next = RESP;
            RESP:   if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            size_q     <= 2'd0;
            lane_q     <= 2'd0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            se_input   <= 32'd0;
            se_control <= 3'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        se_control <= control_next;
                        mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            mem_rd <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_rd   <= 1'b0;
                        se_input <= lane_data;
                    end else if (timeout_hit) begin
                        mem_rd     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_data  <= 32'd0;
                    end
                end
                EXTEND: begin
                    resp_data  <= se_result;
                    resp_error <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_extend_controller.sv
// =============================================================================
//  Module   : tb_load_extend_controller
//  Purpose  : Directed self-checking bench for load_extend_controller.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_load_extend_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] se_input;
    logic [2:0]  se_control;
    logic [31:0] se_result;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_error;

    int n_vec = 0;
    int n_err = 0;

    load_extend_controller #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .se_input   (se_input),
        .se_control (se_control),
        .se_result  (se_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_error (resp_error)
    );

    always #5 clock = ~clock;

    // Reference sign/zero-extend unit standing in for the real extender.
    always_comb begin
        case (se_control)
            3'd1:    se_result = {{16{se_input[15]}}, se_input[15:0]};
            3'd2:    se_result = {{24{se_input[7]}}, se_input[7:0]};
            3'd3:    se_result = {16'd0, se_input[15:0]};
            3'd4:    se_result = {24'd0, se_input[7:0]};
            default: se_result = se_input;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] rdata, input int waits, input int hold,
                           input logic [2:0] exp_ctl, input logic [31:0] exp_in,
                           input logic [31:0] exp_data);
        issue(addr, size, sgn);
        check("mem_rd_t1", {31'd0, mem_rd}, 32'd1);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("se_control", {29'd0, se_control}, {29'd0, exp_ctl});
        for (int i = 0; i < waits; i++) begin
            tick();
            check("mem_rd_wait", {31'd0, mem_rd}, 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        check("mem_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("se_input", se_input, exp_in);
        check("resp_valid_early", {31'd0, resp_valid}, 32'd0);
        tick();
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_data", resp_data, exp_data);
        check("resp_error", {31'd0, resp_error}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            resp_ready = 1'b0;
            tick();
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_data", resp_data, exp_data);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_valid_clr", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_bad(input logic [31:0] addr, input logic [1:0] size);
        issue(addr, size, 1'b1);
        check("bad_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("bad_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("bad_resp_error", {31'd0, resp_error}, 32'd1);
        check("bad_resp_data", resp_data, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bad_valid_clr", {31'd0, resp_valid}, 32'd0);
        check("bad_mem_rd_after", {31'd0, mem_rd}, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_se_input", se_input, 32'd0);
        check("rst_se_control", {29'd0, se_control}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Lane/extension patterns on the same memory word.
        do_load(32'h103, 2'd0, 1'b1, 32'h80FF_1234, 0, 0, 3'd2, 32'h0000_0080, 32'hFFFF_FF80);
        do_load(32'h102, 2'd1, 1'b0, 32'h80FF_1234, 3, 0, 3'd3, 32'h0000_80FF, 32'h0000_80FF);
        do_load(32'h101, 2'd0, 1'b1, 32'h80FF_1234, 1, 0, 3'd2, 32'h0000_0012, 32'h0000_0012);
        do_load(32'h102, 2'd0, 1'b0, 32'h80FF_1234, 0, 0, 3'd4, 32'h0000_00FF, 32'h0000_00FF);
        do_load(32'h100, 2'd1, 1'b1, 32'h80FF_1234, 0, 0, 3'd1, 32'h0000_1234, 32'h0000_1234);
        do_load(32'h102, 2'd1, 1'b1, 32'h80FF_1234, 2, 0, 3'd1, 32'h0000_80FF, 32'hFFFF_80FF);

        do_bad(32'h101, 2'd1);
        do_bad(32'h102, 2'd2);
        do_bad(32'h100, 2'd3);

        // Backpressure, then a request straight after the handshake.
        do_load(32'h200, 2'd2, 1'b1, 32'hDEAD_BEEF, 0, 5, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load(32'h204, 2'd0, 1'b0, 32'hDEAD_BEEF, 0, 0, 3'd4, 32'h0000_00EF, 32'h0000_00EF);

`ifdef LOAD_TIMEOUT_EN
        begin
            int rd_cycles;
            issue(32'h300, 2'd2, 1'b0);
            rd_cycles = 0;
            while (mem_rd && rd_cycles < 40) begin
                rd_cycles++;
                tick();
            end
            check("timeout_rd_cycles", rd_cycles, 32'd15);
            check("timeout_valid", {31'd0, resp_valid}, 32'd1);
            check("timeout_error", {31'd0, resp_error}, 32'd1);
            check("timeout_data", resp_data, 32'd0);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        do_load(32'h300, 2'd2, 1'b0, 32'h1357_9BDF, 14, 0, 3'd0, 32'h1357_9BDF, 32'h1357_9BDF);
`else
        do_load(32'h300, 2'd2, 1'b0, 32'h1357_9BDF, 20, 0, 3'd0, 32'h1357_9BDF, 32'h1357_9BDF);
`endif

        // Reset while waiting in READ, then a stale ack.
        issue(32'h400, 2'd2, 1'b0);
        tick();
        tick();
        check("pre_rst_mem_rd", {31'd0, mem_rd}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_se_control", {29'd0, se_control}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("late_ack_se_input", se_input, 32'd0);
        check("late_ack_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("late_ack_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("late_ack_resp_valid", {31'd0, resp_valid}, 32'd0);
        do_load(32'h402, 2'd1, 1'b1, 32'h8001_7FFE, 1, 0, 3'd1, 32'h0000_8001, 32'hFFFF_8001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
